// File: rtl/manchester_deserializer.sv
// manchester_deserializer
//   Hunts a one-chip-per-clock Manchester line for the encoded sync byte.
//   Once locked, decodes each 16-chip group (bit b = chips {b, ~b}, MSB
//   first) into a byte and offers it on a single-entry AXI-Stream master.
//
// Ports
//   aclk           clock, one line chip per rising edge
//   areset         asynchronous active-high reset
//   serial_in      Manchester chip stream, synchronous to aclk
//   m_axis_tdata   decoded byte
//   m_axis_tvalid  byte valid
//   m_axis_tready  downstream ready
//   locked         high while byte framing is established
//   decode_err     one-cycle pulse on an invalid chip pair in a locked word
//   overflow       one-cycle pulse when a decoded byte is dropped
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | sliding window compared against encode(SYNC_BYTE) every chip
// LOCKED | chip_cnt tracks word phase; a word is decoded every 16 chips
module manchester_deserializer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hD5,
    parameter bit         FORWARD_SYNC = 1'b0
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       serial_in,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       locked,
    output logic       decode_err,
    output logic       overflow
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic logic [15:0] encode(input logic [7:0] b);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            e[2*i+1] = b[i];
            e[2*i]   = ~b[i];
        end
        return e;
    endfunction

    localparam logic [15:0] SYNC_CHIPS = encode(SYNC_BYTE);

    logic [15:0] window_q, window_d;
    logic [3:0]  chip_cnt_q, chip_cnt_d;
    logic [0:0]  state_q, state_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        decode_err_q, decode_err_d;
    logic        overflow_q, overflow_d;

    logic [7:0]  word_byte;
    logic        pairs_ok;
    logic        deliver;

    always_comb begin
        window_d = {window_q[14:0], serial_in};

        // Decode the window including the chip arriving this edge.
        pairs_ok  = 1'b1;
        word_byte = '0;
        for (int i = 0; i < 8; i++) begin
            word_byte[i] = window_d[2*i+1];
            if (window_d[2*i+1] == window_d[2*i]) begin
                pairs_ok = 1'b0;
            end
        end

        state_d      = state_q;
        chip_cnt_d   = chip_cnt_q;
        deliver      = 1'b0;
        decode_err_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (window_d == SYNC_CHIPS) begin
                    state_d    = ST_LOCKED;
                    chip_cnt_d = 4'd0;
                    // word_byte equals SYNC_BYTE here, so it can be forwarded as is
                    deliver    = FORWARD_SYNC;
                end
            end
            default: begin
                chip_cnt_d = chip_cnt_q + 4'd1;
                if (chip_cnt_q == 4'd15) begin
                    if (pairs_ok) begin
                        deliver = 1'b1;
                    end else begin
                        decode_err_d = 1'b1;
                        state_d      = ST_HUNT;
                    end
                end
            end
        endcase

        // Single-entry output register; the line cannot be stalled, so a
        // byte arriving while one is still held is dropped.
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overflow_d = 1'b0;
        if (deliver) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = word_byte;
                tvalid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            window_q     <= '0;
            chip_cnt_q   <= '0;
            state_q      <= ST_HUNT;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            decode_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            window_q     <= window_d;
            chip_cnt_q   <= chip_cnt_d;
            state_q      <= state_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            decode_err_q <= decode_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign locked        = (state_q == ST_LOCKED);
    assign decode_err    = decode_err_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_manchester_deserializer.sv
// tb_manchester_deserializer
//   Drives two deserializers (FORWARD_SYNC = 0 and 1) from one chip stream
//   and compares both against a byte-level behavioural model every cycle,
//   plus directed literal expectations per scenario.
module tb_manchester_deserializer;

    localparam logic [7:0] SYNC = 8'hD5;

    logic       aclk = 1'b0;
    logic       areset = 1'b0;
    logic       serial_in = 1'b0;
    logic       tready = 1'b1;

    logic [7:0] tdata0, tdata1;
    logic       tvalid0, tvalid1, locked0, locked1, err0, err1, ovf0, ovf1;

    manchester_deserializer #(.SYNC_BYTE(SYNC), .FORWARD_SYNC(1'b0)) dut0 (
        .aclk(aclk), .areset(areset), .serial_in(serial_in),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
        .locked(locked0), .decode_err(err0), .overflow(ovf0));

    manchester_deserializer #(.SYNC_BYTE(SYNC), .FORWARD_SYNC(1'b1)) dut1 (
        .aclk(aclk), .areset(areset), .serial_in(serial_in),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
        .locked(locked1), .decode_err(err1), .overflow(ovf1));

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] dt[2];
    logic       dv[2], dl[2], de[2], dov[2];
    always_comb begin
        dt[0] = tdata0;  dt[1] = tdata1;
        dv[0] = tvalid0; dv[1] = tvalid1;
        dl[0] = locked0; dl[1] = locked1;
        de[0] = err0;    de[1] = err1;
        dov[0] = ovf0;   dov[1] = ovf1;
    end

    // ---------------- behavioural model ----------------
    bit         chips[$];          // last 16 line chips, oldest first
    bit         m_locked;
    int         m_phase;           // chips received since lock / last word
    logic [7:0] m_data[2];
    bit         m_valid[2], m_err[2], m_ovf[2];

    always @(posedge aclk or posedge areset) begin
        bit         ok, done, fwd, good;
        logic [7:0] word;
        if (areset) begin
            chips.delete();
            for (int k = 0; k < 16; k++) chips.push_back(1'b0);
            m_locked = 0;
            m_phase  = 0;
            for (int i = 0; i < 2; i++) begin
                m_data[i] = 8'h00; m_valid[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
            end
        end else begin
            chips.push_back(serial_in);
            chips.pop_front();
            ok = 1;
            for (int b = 0; b < 8; b++) begin
                if (chips[2*b] == chips[2*b+1]) ok = 0;
                word[7-b] = chips[2*b];
            end
            done = 0; fwd = 0; good = 0;
            if (!m_locked) begin
                if (ok && word == SYNC) begin
                    m_locked = 1; m_phase = 0; fwd = 1;
                end
            end else begin
                m_phase++;
                if (m_phase == 16) begin
                    m_phase = 0; done = 1; good = ok;
                    if (!ok) m_locked = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                bit d;
                d = (done && good) || (fwd && i == 1);
                m_err[i] = done && !good;
                m_ovf[i] = 0;
                if (d) begin
                    if (!m_valid[i] || tready) begin
                        m_valid[i] = 1; m_data[i] = word;
                    end else begin
                        m_ovf[i] = 1;
                    end
                end else if (m_valid[i] && tready) begin
                    m_valid[i] = 0;
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    logic [7:0] xfer0[$], xfer1[$];
    int err_cnt[2], ovf_cnt[2];

    always @(negedge aclk) begin
        if (checking && !areset) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("tvalid[%0d]", i), dv[i], m_valid[i]);
                if (m_valid[i]) check($sformatf("tdata[%0d]", i), dt[i], m_data[i]);
                check($sformatf("locked[%0d]", i), dl[i], m_locked);
                check($sformatf("decode_err[%0d]", i), de[i], m_err[i]);
                check($sformatf("overflow[%0d]", i), dov[i], m_ovf[i]);
                check($sformatf("err_and_ovf[%0d]", i), de[i] & dov[i], 0);
                if (de[i]) err_cnt[i]++;
                if (dov[i]) ovf_cnt[i]++;
            end
            if (tvalid0 && tready) xfer0.push_back(tdata0);
            if (tvalid1 && tready) xfer1.push_back(tdata1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_chip(input logic c);
        serial_in = c;
        @(posedge aclk);
        #1;
    endtask

    // chip k of byte b: even k carries bit 7-k/2, odd k its complement
    task automatic send_chips(input logic [7:0] b, input int from, input int to);
        for (int k = from; k < to; k++) begin
            if (k % 2 == 0) send_chip(b[7 - k/2]);
            else            send_chip(~b[7 - k/2]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_chips(b, 0, 16);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send_chip(1'b0);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        serial_in = 1'b0;
        areset = 1'b1;
        #3;
        areset = 1'b0;
        xfer0.delete(); xfer1.delete();
        err_cnt[0] = 0; err_cnt[1] = 0; ovf_cnt[0] = 0; ovf_cnt[1] = 0;
        checking = 1;
    endtask

    task automatic check_xfers(input string name, input int inst, input int n,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp[4];
        int         sz;
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        sz = (inst == 0) ? xfer0.size() : xfer1.size();
        check({name, "_count"}, sz, n);
        for (int k = 0; k < n && k < sz; k++)
            check($sformatf("%s_byte%0d", name, k),
                  (inst == 0) ? xfer0[k] : xfer1[k], exp[k]);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // idle line: no lock, no output, no errors in HUNT
        do_reset();
        check("rst_tvalid", tvalid0, 0);
        check("rst_tdata", tdata0, 0);
        check("rst_locked", locked0, 0);
        idle(100);
        check("idle_locked", locked0, 0);
        check("idle_tvalid", tvalid0, 0);
        check("idle_err_cnt", err_cnt[0], 0);

        // sync + 3C + A5
        do_reset();
        tready = 1'b1;
        send_chips(SYNC, 0, 15);
        check("lock_before_last", locked0, 0);
        send_chips(SYNC, 15, 16);
        check("lock_at_last", locked0, 1);
        check("fwd_sync_valid", tvalid1, 1);
        check("fwd_sync_data", tdata1, 8'hD5);
        send_chips(8'h3C, 0, 15);
        check("3c_not_yet", tvalid0, 0);
        send_chips(8'h3C, 15, 16);
        check("3c_valid", tvalid0, 1);
        check("3c_data", tdata0, 8'h3C);
        send_chips(8'hA5, 0, 15);
        check("a5_not_yet", tvalid0, 0);
        send_chips(8'hA5, 15, 16);
        check("a5_valid", tvalid0, 1);
        check("a5_data", tdata0, 8'hA5);
        idle(20);
        check_xfers("t2_dut0", 0, 2, 8'h3C, 8'hA5, 8'h00, 8'h00);
        check_xfers("t2_dut1", 1, 3, 8'hD5, 8'h3C, 8'hA5, 8'h00);

        // decode error on idle word, then relock
        do_reset();
        send_byte(SYNC);
        send_byte(8'h11);
        check("11_data", tdata0, 8'h11);
        idle(15);
        check("err_not_yet", err0, 0);
        check("still_locked", locked0, 1);
        idle(1);
        check("err_pulse", err0, 1);
        check("unlock_on_err", locked0, 0);
        send_byte(SYNC);
        check("relock", locked0, 1);
        send_byte(8'h77);
        check("77_data", tdata0, 8'h77);
        idle(5);
        check("t3_err_cnt", err_cnt[0], 1);
        check_xfers("t3_dut0", 0, 2, 8'h11, 8'h77, 8'h00, 8'h00);
        check_xfers("t3_dut1", 1, 4, 8'hD5, 8'h11, 8'hD5, 8'h77);

        // backpressure: second byte dropped
        do_reset();
        tready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h01);
        check("01_valid", tvalid0, 1);
        check("01_data", tdata0, 8'h01);
        send_chips(8'h02, 0, 15);
        check("ovf_not_yet", ovf0, 0);
        send_chips(8'h02, 15, 16);
        check("ovf_pulse", ovf0, 1);
        check("held_data", tdata0, 8'h01);
        send_chip(1'b0);
        check("ovf_one_cycle", ovf0, 0);
        tready = 1'b1;
        idle(4);
        check("t4_ovf_cnt0", ovf_cnt[0], 1);
        check("t4_ovf_cnt1", ovf_cnt[1], 2);
        check_xfers("t4_dut0", 0, 1, 8'h01, 8'h00, 8'h00, 8'h00);
        check_xfers("t4_dut1", 1, 1, 8'hD5, 8'h00, 8'h00, 8'h00);

        // asynchronous reset seven chips into a locked word
        do_reset();
        tready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h42);
        send_chips(8'h5A, 0, 7);
        check("pre_rst_locked", locked0, 1);
        check("pre_rst_valid", tvalid0, 1);
        areset = 1'b1;
        #1;
        check("arst_locked", locked0, 0);
        check("arst_tvalid0", tvalid0, 0);
        check("arst_tdata0", tdata0, 0);
        check("arst_tvalid1", tvalid1, 0);
        check("arst_tdata1", tdata1, 0);
        check("arst_err", err0, 0);
        check("arst_ovf", ovf1, 0);
        #2;
        areset = 1'b0;
        xfer0.delete(); xfer1.delete();
        tready = 1'b1;
        send_byte(8'hA5);
        check("no_lock_without_sync", locked0, 0);
        check("no_output_without_sync", tvalid0, 0);
        send_byte(SYNC);
        check("fresh_lock", locked0, 1);
        send_byte(8'h3C);
        check("post_rst_data", tdata0, 8'h3C);
        idle(3);
        check_xfers("t5_dut0", 0, 1, 8'h3C, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
